sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO buffer with full/empty and programmable almost-full/almost-empty flags, occupancy count, sticky overflow/underflow error flags and a synchronous flush. It is the next generation of the team's dual-port memory buffer. Data width, depth and thresholds are now generic. Writes into a full FIFO and reads from an empty one are rejected and recorded, not silently corrupting state. It sits between a producer and a consumer in the same clock domain and exposes enough status for both to throttle without external bookkeeping.

---
 rtl/sync_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, threshold flags,
// sticky overflow/underflow errors and a synchronous flush.
module sync_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              valid_q,  valid_d;
  logic              ovf_q,    ovf_d;
  logic              udf_q,    udf_d;

  logic pop_ok;
  logic push_ok;
  logic mem_we;

  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign count_o        = count_q;
  assign data_o         = data_q;
  assign valid_o        = valid_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = rd_en_i && !empty_o;
  assign push_ok = wr_en_i && (!full_o || pop_ok);
  assign mem_we  = push_ok && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        data_d   = mem[rd_ptr_q];
        valid_d  = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en_i && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (rd_en_i && !pop_ok) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: table-driven fill/drain plus
// hand sequences for reset, overflow, boundary and flush corner cases.
module tb_sync_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_i;
  logic              wr_en_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [CW-1:0]     count_o;
  logic              overflow_o;
  logic              underflow_o;

  sync_fifo_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_THRESH(6),
    .AE_THRESH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr_i),
    .wr_en_i       (wr_en_i),
    .data_i        (data_i),
    .rd_en_i       (rd_en_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t tbl [16];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq [$];
  logic [7:0] exp_q [$];
  logic [7:0] mdata = '0;
  logic       mvalid = 1'b0;
  logic       movf = 1'b0;
  logic       mudf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", int'(count_o), n);
    chk("full", int'(full_o), int'(n == DEPTH));
    chk("empty", int'(empty_o), int'(n == 0));
    chk("almost_full", int'(almost_full_o), int'(n >= 6));
    chk("almost_empty", int'(almost_empty_o), int'(n <= 2));
    chk("overflow", int'(overflow_o), int'(movf));
    chk("underflow", int'(underflow_o), int'(mudf));
    chk("valid", int'(valid_o), int'(mvalid));
    chk("data", int'(data_o), int'(mdata));
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    logic pop_ok, push_ok;
    @(negedge clk);
    wr_en_i = w;
    rd_en_i = r;
    clr_i   = c;
    data_i  = d;
    pop_ok  = r && !c && (mq.size() != 0);
    push_ok = w && !c && (mq.size() < DEPTH || pop_ok);
    if (c) begin
      mq.delete();
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      if (pop_ok) exp_q.push_back(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (w && !push_ok) movf = 1'b1;
      if (r && !pop_ok) mudf = 1'b1;
    end
    mvalid = pop_ok;
    if (pop_ok) mdata = exp_q.pop_front();
    @(posedge clk);
    #1;
    check_model();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill 0x10..0x17 then drain; expected status entered by hand.
    tbl[0]  = '{1'b1, 1'b0, 8'h10, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'h11, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h12, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h13, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h14, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h15, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h16, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h17, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    clr_i = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].din);
      chk("tbl_count", int'(count_o), int'(tbl[i].cnt));
      chk("tbl_full", int'(full_o), int'(tbl[i].full));
      chk("tbl_empty", int'(empty_o), int'(tbl[i].empty));
      chk("tbl_af", int'(almost_full_o), int'(tbl[i].af));
      chk("tbl_ae", int'(almost_empty_o), int'(tbl[i].ae));
      if (i >= 8) chk("tbl_data", int'(data_o), 16 + i - 8);
    end

    // Overflow: push 0xAA into a full FIFO, then drain.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(16 + i));
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_count", int'(count_o), 8);
    chk("ovf_flag", int'(overflow_o), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("ovf_drain", int'(data_o), 16 + i);
    end

    // Asynchronous reset mid-stream with count=5 and overflow set.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    movf = 1'b0;
    mudf = 1'b0;
    mvalid = 1'b0;
    mdata = '0;
    check_model();
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_count", int'(count_o), 0);
    chk("post_rst_empty", int'(empty_o), 1);
    step(1'b1, 1'b0, 1'b0, 8'h77);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("first_push_after_rst", int'(data_o), 8'h77);

    // Push and pop together at full: no overflow, count stays 8.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("full_both_data", int'(data_o), 8'h20);
    chk("full_both_count", int'(count_o), 8);
    chk("full_both_ovf", int'(overflow_o), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("full_both_last", int'(data_o), 8'h55);

    // Push and pop together at empty: pop rejected, no read-through.
    step(1'b1, 1'b1, 1'b0, 8'h33);
    chk("empty_both_udf", int'(underflow_o), 1);
    chk("empty_both_valid", int'(valid_o), 0);
    chk("empty_both_count", int'(count_o), 1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("empty_both_next", int'(data_o), 8'h33);

    // Wrap-around: hold count at 3 while streaming concurrently.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    for (int i = 3; i < 23; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i));
      chk("wrap_data", int'(data_o), i - 3);
      chk("wrap_count", int'(count_o), 3);
    end

    // Flush with count=5 and overflow set, push in the same cycle ignored.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_flush_count", int'(count_o), 5);
    step(1'b1, 1'b0, 1'b1, 8'hCC);
    chk("flush_count", int'(count_o), 0);
    chk("flush_empty", int'(empty_o), 1);
    chk("flush_ovf", int'(overflow_o), 0);
    chk("flush_hold_data", int'(data_o), 8'h62);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("flush_push_ignored_udf", int'(underflow_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
